// File: rtl/dmem_sized_pipe.sv
// Byte/half/word data memory for the MEM stage: sized loads and stores, sign/zero extension,
// READ_LAT-deep response pipeline, and a post-reset clear sweep that gates request acceptance.
module dmem_sized_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned READ_LAT  = 1,
   parameter int unsigned INIT_ZERO = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_uns,
   input  logic [XLEN-1:0] req_addr,
   input  logic [31:0]     req_wdata,
   output logic            resp_valid,
   output logic [31:0]     resp_rdata,
   output logic            resp_err,
   output logic            init_done
);

   localparam int unsigned IDXW = $clog2(DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic [31:0]     mem [DEPTH];

   logic            accept;
   logic [1:0]      off;
   logic [IDXW-1:0] idx;
   logic            err_size;
   logic            err_align;
   logic            err_range;
   logic            acc_err;
   logic [3:0]      be;
   logic [31:0]     wlane;
   logic            st_en;
   logic            sweep_en;
   logic [31:0]     rword;
   logic [7:0]      b8;
   logic [15:0]     h16;
   logic [31:0]     ldata;
   logic [31:0]     rdata_in;

   logic            pv [READ_LAT];
   logic [31:0]     pd [READ_LAT];
   logic            pe [READ_LAT];

   assign accept = req_valid & req_ready;
   assign off    = req_addr[1:0];
   assign idx    = req_addr[IDXW+1:2];

   // Any set bit above the word index puts the address past the array; no aliasing.
   assign err_range = (req_addr >> (IDXW + 2)) != '0;

   always_comb begin
      err_size  = (req_size == 2'b11);
      err_align = ((req_size == 2'b01) && off[0]) ||
                  ((req_size == 2'b10) && (off != 2'b00));
      acc_err   = err_size | err_align | err_range;
   end

   always_comb begin
      be    = 4'b1111;
      wlane = req_wdata;
      case (req_size)
         2'b00: begin
            be    = 4'b0001 << off;
            wlane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = req_wdata;
         end
      endcase
   end

   // An X-valued address makes st_en X, so the store branch below is not taken.
   assign st_en    = accept & req_we & ~acc_err;
   assign sweep_en = (INIT_ZERO != 0) && (state == S_INIT) && rst_n;

   always_ff @(posedge clk) begin
      if (sweep_en) begin
         mem[ptr] <= '0;
      end else if (st_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   assign rword = mem[idx];

   always_comb begin
      b8    = rword[8*off +: 8];
      h16   = rword[16*off[1] +: 16];
      ldata = rword;
      case (req_size)
         2'b00:   ldata = req_uns ? {24'h0, b8}  : {{24{b8[7]}}, b8};
         2'b01:   ldata = req_uns ? {16'h0, h16} : {{16{h16[15]}}, h16};
         default: ldata = rword;
      endcase
      rdata_in = (req_we || acc_err) ? '0 : ldata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         ptr       <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               if ((INIT_ZERO == 0) || (ptr == IDXW'(DEPTH - 1))) begin
                  state     <= S_RUN;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            S_RUN: begin
               state     <= S_RUN;
               req_ready <= 1'b1;
               init_done <= 1'b1;
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // Stage 0 captures the load result at the accept edge; later stages only delay it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < READ_LAT; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
            pe[i] <= 1'b0;
         end
      end else begin
         pv[0] <= accept;
         pd[0] <= accept ? rdata_in : '0;
         pe[0] <= accept & acc_err;
         for (int unsigned i = 1; i < READ_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
            pe[i] <= pe[i-1];
         end
      end
   end

   assign resp_valid = pv[READ_LAT-1];
   assign resp_rdata = pd[READ_LAT-1];
   assign resp_err   = pe[READ_LAT-1];

endmodule

// File: tb/tb_dmem_sized_pipe.sv
// Scoreboarded bench for dmem_sized_pipe (DEPTH=16, READ_LAT=3): sweep timing, sized access
// vectors, error cases, latency/ordering and reset flush with re-clear.
module tb_dmem_sized_pipe;

   localparam int DEPTH = 16;
   localparam int RL    = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        init_done;

   always #5 clk = ~clk;

   dmem_sized_pipe #(.XLEN(32), .DEPTH(DEPTH), .READ_LAT(RL), .INIT_ZERO(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .init_done(init_done)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t        sb[$];
   exp_t        e;
   vec_t        tbl[$];
   logic [31:0] exp_rdata;
   logic        exp_err;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expected result is queued at the edge where the DUT accepts the request.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && req_valid && req_ready)
         sb.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc});
   end

   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            check("resp_latency", cyc, e.acc + RL - 1);
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_uns   = uns;
      req_addr  = a;
      req_wdata = wd;
      exp_rdata = er;
      exp_err   = ee;
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 4) idle();
      end
      check(name, n, DEPTH);
      check({name, "_init_done"}, {31'd0, init_done}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
      tbl.push_back('{we: we, size: sz, uns: uns, addr: a, wdata: wd, rdata: er, err: ee});
   endtask

   initial begin
      add(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0);
      add(0, 2'b00, 1, 32'h09, 32'h0, 32'h000000BE, 0);
      add(0, 2'b00, 0, 32'h0B, 32'h0, 32'hFFFFFFDE, 0);
      add(0, 2'b01, 0, 32'h0A, 32'h0, 32'hFFFFDEAD, 0);
      add(0, 2'b01, 1, 32'h0A, 32'h0, 32'h0000DEAD, 0);
      add(0, 2'b00, 0, 32'h08, 32'h0, 32'hFFFFFFEF, 0);
      add(1, 2'b10, 0, 32'h04, 32'hAABBCCDD, 32'h0, 0);
      add(1, 2'b01, 0, 32'h06, 32'h99991234, 32'h0, 0);
      add(0, 2'b10, 0, 32'h04, 32'h0, 32'h1234CCDD, 0);
      add(1, 2'b00, 0, 32'h05, 32'hABCDEF7F, 32'h0, 0);
      add(0, 2'b10, 0, 32'h04, 32'h0, 32'h12347FDD, 0);
      add(0, 2'b00, 0, 32'h05, 32'h0, 32'h0000007F, 0);
      add(0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1);
      add(0, 2'b01, 0, 32'h01, 32'h0, 32'h0, 1);
      add(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1);
      add(0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 1);
      add(1, 2'b10, 0, 32'h00, 32'hCAFEF00D, 32'h0, 0);
      add(1, 2'b10, 0, 32'h40, 32'hFFFFFFFF, 32'h0, 1);
      add(1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 32'h0, 1);
      add(1, 2'b01, 0, 32'h03, 32'hFFFFFFFF, 32'h0, 1);
      add(1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
      add(0, 2'b10, 0, 32'h00, 32'h0, 32'hCAFEF00D, 0);
      add(0, 2'b10, 0, 32'h10000000, 32'h0, 32'h0, 1);
      add(1, 2'b01, 0, 32'h3E, 32'h00008001, 32'h0, 0);
      add(0, 2'b01, 0, 32'h3E, 32'h0, 32'hFFFF8001, 0);
      add(0, 2'b10, 0, 32'h3C, 32'h0, 32'h80010000, 0);

      rst_n     = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      req_size  = 2'b10;
      req_uns   = 1'b0;
      idle();
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      @(negedge clk);

      // A store presented during the sweep must be refused.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h55555555;
      rst_n     = 1'b1;
      wait_ready("sweep_cycles");

      for (int i = 0; i < DEPTH; i++) issue(0, 2'b10, 0, 32'(i * 4), 32'h0, 32'h0, 0);
      idle();
      drain();

      foreach (tbl[k]) issue(tbl[k].we, tbl[k].size, tbl[k].uns, tbl[k].addr,
                             tbl[k].wdata, tbl[k].rdata, tbl[k].err);
      idle();
      drain();

      // Two loads in flight, then reset: both responses must vanish.
      issue(0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0);
      issue(0, 2'b10, 0, 32'h04, 32'h0, 32'h12347FDD, 0);
      idle();
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("flush_req_ready", {31'd0, req_ready}, 32'd0);
      check("flush_init_done", {31'd0, init_done}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_hold", {31'd0, resp_valid}, 32'd0);
      end
      rst_n = 1'b1;
      wait_ready("resweep_cycles");

      issue(0, 2'b10, 0, 32'h08, 32'h0, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h04, 32'h0, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h00, 32'h0, 32'h0, 0);
      issue(0, 2'b10, 0, 32'h3C, 32'h0, 32'h0, 0);
      idle();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
